// File: rtl/updi_pkg.sv
// rtl/updi_pkg.sv - shared UPDI break timing constants and detector state type
package updi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW1,
        GAP,
        LOW2
    } state_t;

    // Shared with updi_double_break so generator and detector agree on BREAK length
    localparam int UPDI_BREAK_CLK_DEFAULT   = 10;
    localparam int UPDI_GAP_MAX_CLK_DEFAULT = 40;

endpackage

// File: rtl/updi_sync.sv
// rtl/updi_sync.sv - multi-flop synchroniser with configurable reset level
module updi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/updi_break_detect.sv
// rtl/updi_break_detect.sv - UPDI BREAK / DOUBLE BREAK detector on the receive line
module updi_break_detect
    import updi_pkg::*;
#(
    parameter int BREAK_CLK   = UPDI_BREAK_CLK_DEFAULT,
    parameter int GAP_MAX_CLK = UPDI_GAP_MAX_CLK_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic rx,
    output logic line_low,
    output logic break_det,
    output logic double_break,
    output logic busy
);

    localparam int LW = $clog2(BREAK_CLK + 1);
    localparam int GW = $clog2(GAP_MAX_CLK + 1);
    localparam logic [LW-1:0] LOW_LIM = LW'(BREAK_CLK);
    localparam logic [GW-1:0] GAP_LIM = GW'(GAP_MAX_CLK);

    logic          rx_s;
    state_t        state, state_n;
    logic [LW-1:0] low_cnt, low_cnt_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic          brk_n, dbl_n;

    updi_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            low_cnt      <= '0;
            gap_cnt      <= '0;
            break_det    <= 1'b0;
            double_break <= 1'b0;
        end else begin
            state        <= state_n;
            low_cnt      <= low_cnt_n;
            gap_cnt      <= gap_cnt_n;
            break_det    <= brk_n;
            double_break <= dbl_n;
        end
    end

    always_comb begin
        state_n   = state;
        low_cnt_n = low_cnt;
        gap_cnt_n = gap_cnt;
        brk_n     = 1'b0;
        dbl_n     = 1'b0;
        if (!en) begin
            state_n   = IDLE;
            low_cnt_n = '0;
            gap_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    low_cnt_n = '0;
                    gap_cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = LOW1;
                        low_cnt_n = LW'(1);
                    end
                end
                LOW1, LOW2: begin
                    if (!rx_s) begin
                        if (low_cnt != LOW_LIM) low_cnt_n = low_cnt + LW'(1);
                    end else begin
                        low_cnt_n = '0;
                        state_n   = IDLE;
                        if (low_cnt >= LOW_LIM) begin
                            brk_n = 1'b1;
                            if (state == LOW2) begin
                                dbl_n = 1'b1;
                            end else begin
                                // the release cycle is the first high cycle of the gap
                                state_n   = GAP;
                                gap_cnt_n = GW'(1);
                            end
                        end
                    end
                end
                GAP: begin
                    if (!rx_s) begin
                        state_n   = LOW2;
                        low_cnt_n = LW'(1);
                        gap_cnt_n = '0;
                    end else begin
                        gap_cnt_n = gap_cnt + GW'(1);
                        if (gap_cnt_n >= GAP_LIM) state_n = IDLE;
                    end
                end
                default: begin
                    state_n   = IDLE;
                    low_cnt_n = '0;
                    gap_cnt_n = '0;
                end
            endcase
        end
    end

    assign line_low = ~rx_s;
    assign busy     = (state != IDLE);

endmodule
